// File: rtl/switch_event_queue.sv
// Synchronises and debounces NUM_SW switch pins, converts each press into a
// one-based channel code, and queues the codes for the processor to pop.
module switch_event_queue #(
  parameter  int NUM_SW         = 3,
  parameter  int DEBOUNCE_TICKS = 4,
  parameter  int FIFO_DEPTH     = 4,
  localparam int VAL_W          = $clog2(NUM_SW + 1),
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pulse_en,
  input  logic [31:0]       addr,
  input  logic              rd,
  input  logic [NUM_SW-1:0] switches,
  output logic [VAL_W-1:0]  switch_val,
  output logic [CNT_W-1:0]  ev_count,
  output logic              not_empty,
  output logic              overflow
);

  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_SW-1:0] sync1_reg, sync2_reg;
  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] stable_d_reg;
  logic [NUM_SW-1:0] pending_reg;
  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] sel_onehot;
  logic [VAL_W-1:0]  sel_code;

  logic [VAL_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;

  logic have_ev, empty, full, pop_req, pop, stat_rd, push, drop;

  // Only the decoded address bits matter; the rest are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:24], addr[22:3]};

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= switches;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_debounce
      logic [DB_W-1:0] cnt_reg;
      logic            stable_reg;

      // A level is accepted only after DEBOUNCE_TICKS consecutive differing ticks.
      always_ff @(posedge clk) begin
        if (clr) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else if (sync2_reg[gi] == stable_reg) begin
          cnt_reg <= '0;
        end else if (pulse_en) begin
          if (cnt_reg == DB_W'(DEBOUNCE_TICKS - 1)) begin
            stable_reg <= sync2_reg[gi];
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate

  assign rise = stable & ~stable_d_reg;

  // Lowest pending channel wins; one event leaves the arbiter per cycle.
  always_comb begin
    sel_onehot = pending_reg & (~pending_reg + NUM_SW'(1));
    sel_code   = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_code = VAL_W'(i + 1);
    end
  end

  assign have_ev = |pending_reg;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop_req = rd && addr[23] && (addr[2:0] == 3'b001);
  assign stat_rd = rd && addr[23] && (addr[2:0] == 3'b010);
  assign pop     = pop_req && !empty;
  assign push    = have_ev && (!full || pop);
  assign drop    = have_ev && full && !pop;

  always_ff @(posedge clk) begin
    if (clr) begin
      stable_d_reg <= '0;
      pending_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      stable_d_reg <= stable;
      pending_reg  <= (pending_reg & ~sel_onehot) | rise;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // A drop in the same cycle as a status read keeps the flag set.
      if (drop)         overflow_reg <= 1'b1;
      else if (stat_rd) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= sel_code;
  end

  assign switch_val = empty ? '0 : mem[rd_ptr_reg];
  assign ev_count   = count_reg;
  assign not_empty  = !empty;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_switch_event_queue.sv
// Directed bench for switch_event_queue: expected codes go into a scoreboard
// queue at stimulus time and a monitor checks every pop read against it.
module tb_switch_event_queue;

  localparam logic [31:0] POP_ADDR  = 32'h0080_0001;
  localparam logic [31:0] STAT_ADDR = 32'h0080_0002;

  logic        clk = 1'b0;
  logic        clr, pulse_en, rd;
  logic [31:0] addr;
  logic [2:0]  switches;
  logic [1:0]  switch_val;
  logic [2:0]  ev_count;
  logic        not_empty, overflow;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  switch_event_queue #(
    .NUM_SW(3),
    .DEBOUNCE_TICKS(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .pulse_en(pulse_en),
    .addr(addr),
    .rd(rd),
    .switches(switches),
    .switch_val(switch_val),
    .ev_count(ev_count),
    .not_empty(not_empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_rd();
    rd = 1'b1;
    addr = POP_ADDR;
    @(negedge clk);
    rd = 1'b0;
    addr = '0;
  endtask

  task automatic status_rd();
    rd = 1'b1;
    addr = STAT_ADDR;
    @(negedge clk);
    rd = 1'b0;
    addr = '0;
  endtask

  task automatic press(input logic [2:0] bits);
    switches = bits;
    wait_cyc(12);
    switches = '0;
    wait_cyc(12);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_switch_val"}, switch_val, 0);
    check({tag, "_ev_count"}, ev_count, 0);
    check({tag, "_not_empty"}, not_empty, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  // Monitor: every pop read is compared with the scoreboard head (0 if empty).
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rd && addr[23] && addr[2:0] == 3'b001) begin
        int e;
        e = 0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("pop_val", switch_val, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1; pulse_en = 1'b1; rd = 1'b0; addr = '0; switches = '0;
    wait_cyc(2);
    clr = 1'b0;
    check_idle("reset");
    wait_cyc(50);
    check_idle("idle50");

    // Single press: code visible exactly 8 cycles after the pin rises
    switches = 3'b010;
    exp_q.push_back(2);
    wait_cyc(7);
    check("latency_before", ev_count, 0);
    wait_cyc(1);
    check("latency_count", ev_count, 1);
    check("latency_val", switch_val, 2);
    check("latency_not_empty", not_empty, 1);
    pop_rd();
    check("after_pop_val", switch_val, 0);
    pop_rd();
    check("empty_pop_count", ev_count, 0);
    check("empty_pop_ovf", overflow, 0);
    switches = '0;
    wait_cyc(12);
    check("no_release_event", ev_count, 0);

    // Bounce on bit 0, then hold: one event only
    switches = 3'b001; wait_cyc(1);
    switches = 3'b000; wait_cyc(1);
    switches = 3'b001;
    exp_q.push_back(1);
    wait_cyc(20);
    check("bounce_count", ev_count, 1);
    switches = '0;
    wait_cyc(20);
    check("bounce_release", ev_count, 1);
    pop_rd();
    check("bounce_drained", ev_count, 0);

    // Counter holds without pulse_en
    pulse_en = 1'b0;
    switches = 3'b100;
    wait_cyc(20);
    check("no_tick_hold", ev_count, 0);
    pulse_en = 1'b1;
    exp_q.push_back(3);
    wait_cyc(5);
    check("tick_resume_before", ev_count, 0);
    wait_cyc(1);
    check("tick_resume_count", ev_count, 1);
    switches = '0;
    wait_cyc(12);
    pop_rd();

    // Simultaneous presses queue on consecutive cycles
    switches = 3'b111;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    wait_cyc(8);
    check("simul_c1", ev_count, 1);
    wait_cyc(1);
    check("simul_c2", ev_count, 2);
    wait_cyc(1);
    check("simul_c3", ev_count, 3);
    pop_rd(); pop_rd(); pop_rd();
    check("simul_drained", ev_count, 0);
    switches = '0;
    wait_cyc(12);

    // Overflow: five presses, four slots
    press(3'b111);
    press(3'b001);
    press(3'b010);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1);
    check("ovf_count", ev_count, 4);
    check("ovf_flag", overflow, 1);
    pop_rd(); pop_rd(); pop_rd(); pop_rd();
    check("ovf_drained", ev_count, 0);
    check("ovf_sticky", overflow, 1);
    status_rd();
    check("ovf_cleared", overflow, 0);

    // Push and pop in the same cycle while full
    press(3'b111);
    press(3'b100);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(3);
    check("refill_count", ev_count, 4);
    switches = 3'b010;
    wait_cyc(7);
    rd = 1'b1;
    addr = POP_ADDR;
    exp_q.push_back(2);
    wait_cyc(1);
    rd = 1'b0;
    addr = '0;
    check("full_pushpop_count", ev_count, 4);
    check("full_pushpop_ovf", overflow, 0);
    switches = '0;
    wait_cyc(12);
    pop_rd(); pop_rd(); pop_rd(); pop_rd();
    check("full_drained", ev_count, 0);

    // Reset mid-operation with switch released
    press(3'b001);
    press(3'b010);
    check("pre_reset_count", ev_count, 2);
    switches = 3'b100;
    wait_cyc(4);
    clr = 1'b1;
    switches = '0;
    wait_cyc(1);
    clr = 1'b0;
    check_idle("midop_reset");
    wait_cyc(20);
    check("no_stale_event", ev_count, 0);

    // Reset while the switch is held: re-accepted after debounce
    switches = 3'b100;
    wait_cyc(5);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    check("held_reset_count", ev_count, 0);
    exp_q.push_back(3);
    wait_cyc(20);
    check("held_reaccept", ev_count, 1);
    switches = '0;
    wait_cyc(12);
    pop_rd();
    check("held_drained", ev_count, 0);

    wait_cyc(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
